// File: rtl/preem_pkg.sv
// Shared definitions for the multi-channel pre-emphasis filter.
//   - default widths and channel count
//   - Q15 shift constant and coefficient reset value (0.875)
//   - sat_to_w(): clamp a signed value to a w-bit signed range
package preem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_CH     = 2;
  localparam int DEF_CH_W   = 4;

  // Coefficient is unsigned Q15: product >>> 15 rescales to sample units.
  localparam int Q15_SHIFT = 15;

  localparam logic [15:0] COEF_RST_Q15 = 16'h7000;

  // Clamp v to [-2**(w-1), 2**(w-1)-1]. Works for w up to 31 bits.
  function automatic logic signed [31:0] sat_to_w(input logic signed [31:0] v,
                                                  input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/preem_chan_hist.sv
// Per-channel history register file for the pre-emphasis filter.
// One combinational read port, one write port, per-entry clear mask.
// Read-before-write: the read returns the value held before this edge's
// write. A clear on the entry being read makes the read return 0.
// On a simultaneous clear and write to the same entry the write wins.
// Ports:
//   clk, rst_n         clock, async active-low reset (all entries -> 0)
//   rd_addr / rd_data  read port
//   we/wr_addr/wr_data write port
//   clr                per-entry clear mask
module preem_chan_hist
  import preem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH     = DEF_CH,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_W-1:0]          rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [CH_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [CH-1:0]            clr
);

  logic signed [DATA_W-1:0] mem [CH];

  // Indices are compared rather than used to subscript, so an address
  // outside 0..CH-1 simply matches no entry.
  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    rd_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (32'(rd_addr) == k) rd_data = clr[k] ? '0 : mem[k];
    end
  end

  // NOTE: the history must be zero after reset, so this small array is built
  //       from flops with a reset rather than an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (we && 32'(wr_addr) == k) mem[k] <= wr_data;
        else if (clr[k])             mem[k] <= '0;
      end
    end
  end

endmodule

// File: rtl/preem_multich.sv
// Multi-channel pre-emphasis filter: y[n] = x[n] - a*x[n-1], a in Q15.
// Two-stage pipeline with valid/ready on both sides, one sample per cycle.
//   S1: read channel history, p = (h*coef) >>> 15, write history.
//   S2: y = x - p at DATA_W+1 bits, drive out_*.
// Optional build macro PREEM_SAT_EN: clamps y to DATA_W bits (sign-extended
// onto out_data) and adds the sat_flag output.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   coef_we, coef_in            coefficient load (unsigned Q15)
//   hist_clr                    per-channel history clear mask
//   in_valid/in_ready/in_ch/in_data      input stream
//   out_valid/out_ready/out_ch/out_data  output stream
//   sat_flag                    (PREEM_SAT_EN only) clamping occurred
module preem_multich
  import preem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                CH       = DEF_CH,
  parameter int                CH_W     = DEF_CH_W,
  parameter int                COEF_W   = DEF_COEF_W,
  parameter logic [COEF_W-1:0] COEF_RST = COEF_W'(COEF_RST_Q15)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   coef_we,
  input  logic [COEF_W-1:0]      coef_in,
  input  logic [CH-1:0]          hist_clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_ch,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
`ifdef PREEM_SAT_EN
  output logic [DATA_W:0]        out_data,
  output logic                   sat_flag
`else
  output logic [DATA_W:0]        out_data
`endif
);

  localparam int Y_W    = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic [COEF_W-1:0]        coef;
  logic                     advance;
  logic                     accept;
  logic                     ch_ok;
  logic signed [DATA_W-1:0] h;
  logic signed [PROD_W-1:0] prod;
  logic signed [Y_W-1:0]    p;
  logic signed [Y_W-1:0]    y;
  logic signed [Y_W-1:0]    y_out;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_x;
  logic signed [Y_W-1:0]    s1_p;
  logic [CH_W-1:0]          s1_ch;

  // The whole pipe moves together whenever the output register can be
  // emptied or overwritten.
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready;
  // Out-of-range channels are still consumed but leave no trace.
  assign ch_ok    = 32'(in_ch) < CH;

  preem_chan_hist #(
    .DATA_W (DATA_W),
    .CH     (CH),
    .CH_W   (CH_W)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (in_ch),
    .rd_data (h),
    .we      (accept && ch_ok),
    .wr_addr (in_ch),
    .wr_data (in_data),
    .clr     (hist_clr)
  );

  // Signed sample times unsigned Q15 coefficient: zero-extend the coefficient
  // so it is never read as negative. >>> floors toward minus infinity.
  assign prod = PROD_W'(h) * $signed(PROD_W'(coef));
  assign p    = Y_W'(prod >>> Q15_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coef <= COEF_RST;
    else if (coef_we) coef <= coef_in;
  end

  // S1: the coefficient in use is the one held before any load this edge,
  // so in-flight samples keep the value they were accepted with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_p     <= '0;
      s1_ch    <= '0;
    end else if (advance) begin
      s1_valid <= accept && ch_ok;
      s1_x     <= in_data;
      s1_p     <= p;
      s1_ch    <= in_ch;
    end
  end

  assign y = Y_W'(s1_x) - s1_p;

`ifdef PREEM_SAT_EN
  logic signed [31:0] y_ext;
  logic signed [31:0] y_sat;
  logic               sat_now;

  assign y_ext   = 32'(y);
  assign y_sat   = sat_to_w(y_ext, DATA_W);
  assign sat_now = (y_sat != y_ext);
  assign y_out   = Y_W'(y_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else if (advance && s1_valid) sat_flag <= sat_now;
  end
`else
  assign y_out = y;
`endif

  // S2: output register only reloads on advance, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_out;
        out_ch   <= s1_ch;
      end
    end
  end

endmodule
